// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned words in a registered FIFO.
// Optional FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module fetch_queue #(
  parameter int unsigned        INSTRSIZE = 31,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [INSTRSIZE:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [INSTRSIZE:0]   imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [INSTRSIZE:0]   imem_rdata,
  input  logic                 redirect,
  input  logic [INSTRSIZE:0]   redirect_pc,
  output logic                 instr_valid,
  output logic [INSTRSIZE:0]   instr,
  output logic [INSTRSIZE:0]   instr_pc,
  output logic [INSTRSIZE:0]   instr_pcplus4,
  input  logic                 instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_flushed
`endif
);

  localparam int unsigned W  = INSTRSIZE + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [W-1:0]  fifo_instr_q [DEPTH];
  logic [W-1:0]  fifo_instr_d [DEPTH];
  logic [W-1:0]  fifo_pc_q    [DEPTH];
  logic [W-1:0]  fifo_pc_d    [DEPTH];
  logic [W-1:0]  tag_q        [DEPTH];
  logic [W-1:0]  tag_d        [DEPTH];
  logic          issue_c, push_c, pop_c;

  // Credits cover both queued words and in-flight requests, including ones to be discarded.
  assign imem_req      = !reset && !redirect &&
                         (({1'b0, count_q} + {1'b0, outstanding_q}) < SW'(DEPTH));
  assign imem_addr     = fetch_pc_q;
  assign instr_valid   = (count_q != '0);
  assign instr         = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc      = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign instr_pcplus4 = instr_valid ? (fifo_pc_q[rd_ptr_q] + W'(4)) : '0;

  assign issue_c = imem_req && imem_gnt;
  assign pop_c   = instr_valid && instr_ready && !redirect;
  assign push_c  = imem_rvalid && (discard_q == '0) && !redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    tag_d         = tag_q;

    // Every response retires its tag, whether kept or dropped.
    if (imem_rvalid) tag_rd_d = tag_rd_q + PW'(1);

    if (redirect) begin
      fetch_pc_d    = {redirect_pc[W-1:2], 2'b00};
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(imem_rvalid);
      discard_d     = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (issue_c) begin
        fetch_pc_d      = fetch_pc_q + W'(4);
        tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d        = tag_wr_q + PW'(1);
      end
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push_c) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
      outstanding_d = outstanding_q + CW'(issue_c) - CW'(imem_rvalid);
      count_d       = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      tag_q         <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      tag_q         <= tag_d;
    end
  end

  // A full FIFO can never receive a word while the credit rule holds.
  assert property (@(posedge clk) disable iff (reset) !(push_c && (count_q == CW'(DEPTH))));

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;

  // Flushed counts cleared FIFO entries plus every response that is thrown away.
  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(pop_c);
    stat_flushed_d = stat_flushed_q;
    if (redirect)
      stat_flushed_d = stat_flushed_q + 32'(count_q) + 32'(imem_rvalid);
    else if (imem_rvalid && (discard_q != '0))
      stat_flushed_d = stat_flushed_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: randomized memory/decode timing against a queue-level reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, instr_pcplus4;
  logic        instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  fetch_queue #(.INSTRSIZE(31), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pcplus4(instr_pcplus4), .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: fetch PC, in-flight fetches (stale after a redirect) and the queue seen by decode.
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  fl_t         m_inflight[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_pc;
  // Memory responder: addresses in request order with the cycle each answer is due.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          mem_last_due;

  int cyc, n_vec, n_err, n_issued, n_popped;
  int gnt_pct, rdy_pct, lat_lo, lat_hi;
  logic        last_req, last_valid;
  logic [31:0] last_addr, last_pc, last_p4, last_instr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_clear();
    m_fifo.delete(); m_inflight.delete(); m_pc = 32'h0;
    mem_addr_q.delete(); mem_due_q.delete(); mem_last_due = 0;
    n_issued = 0; n_popped = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive random handshakes, compare every output against the model, then advance the model.
  task automatic run_cycle(input bit redir, input logic [31:0] rpc);
    bit e_req, e_valid, issued, popped, resp;
    logic [31:0] e_pc, e_instr, e_p4;
    fl_t f;
    int lat, due;
    @(negedge clk);
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    redirect    = redir;
    redirect_pc = rpc;
    resp        = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? word_of(mem_addr_q[0]) : $urandom;
    #1;
    e_req   = !redir && ((m_fifo.size() + m_inflight.size()) < DEPTH);
    e_valid = (m_fifo.size() > 0);
    e_pc    = e_valid ? m_fifo[0] : 32'h0;
    e_instr = e_valid ? word_of(e_pc) : 32'h0;
    e_p4    = e_valid ? e_pc + 32'd4 : 32'h0;
    last_req = imem_req; last_addr = imem_addr; last_valid = instr_valid;
    last_pc = instr_pc; last_p4 = instr_pcplus4; last_instr = instr;
    n_vec++; if (imem_req !== e_req) begin n_err++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, e_req); end
    n_vec++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc); end
    n_vec++; if (instr_valid !== e_valid) begin n_err++; $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, e_valid); end
    n_vec++; if (instr_pc !== e_pc) begin n_err++; $display("FAIL instr_pc cyc=%0d got=%h exp=%h", cyc, instr_pc, e_pc); end
    n_vec++; if (instr !== e_instr) begin n_err++; $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr, e_instr); end
    n_vec++; if (instr_pcplus4 !== e_p4) begin n_err++; $display("FAIL instr_pcplus4 cyc=%0d got=%h exp=%h", cyc, instr_pcplus4, e_p4); end
    issued = e_req && imem_gnt;
    popped = e_valid && instr_ready && !redir;
    if (resp) begin void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front()); end
    if (issued) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = (cyc + lat > mem_last_due + 1) ? cyc + lat : mem_last_due + 1;
      mem_addr_q.push_back(m_pc); mem_due_q.push_back(due); mem_last_due = due;
      n_issued++;
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
      if (resp) void'(m_inflight.pop_front());
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (popped) begin void'(m_fifo.pop_front()); n_popped++; end
      if (resp) begin
        f = m_inflight.pop_front();
        if (!f.stale) m_fifo.push_back(f.pc);
      end
      if (issued) begin m_inflight.push_back('{pc: m_pc, stale: 1'b0}); m_pc = m_pc + 32'd4; end
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    n_vec++; if ({instr, instr_pc, instr_pcplus4} !== 96'h0) begin n_err++; $display("FAIL reset_zero got=%h/%h/%h exp=0", instr, instr_pc, instr_pcplus4); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req_release got=%b exp=1", imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0, 32'h0);
      n_vec++; if (last_addr !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, last_addr, 32'(4 * k)); end
      n_vec++; if (last_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, last_valid, (k >= 2)); end
      if (k >= 2) begin
        n_vec++; if (last_pc !== 32'(4 * (k - 2))) begin n_err++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, last_pc, 32'(4 * (k - 2))); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 1; lat_hi = 1;
    repeat (10) run_cycle(1'b0, 32'h0);
    n_vec++; if (n_issued != DEPTH) begin n_err++; $display("FAIL bp_issued got=%0d exp=%0d", n_issued, DEPTH); end
    n_vec++; if (last_req !== 1'b0) begin n_err++; $display("FAIL bp_req_full got=%b exp=0", last_req); end
    rdy_pct = 100;
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b0, 32'h0);
      n_vec++; if (!last_valid || last_pc !== 32'(4 * k)) begin n_err++; $display("FAIL bp_order k=%0d got=%b/%h exp=1/%h", k, last_valid, last_pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 3; lat_hi = 3;
    repeat (3) run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h40);
    run_cycle(1'b0, 32'h0);
    n_vec++; if (last_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid_after got=%b exp=0", last_valid); end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      run_cycle(1'b0, 32'h0);
      seen = last_valid;
    end
    n_vec++; if (!seen || last_pc !== 32'h40 || last_p4 !== 32'h44 || last_instr !== word_of(32'h40))
      begin n_err++; $display("FAIL flush_first got=%b pc=%h p4=%h exp=1 pc=40 p4=44", seen, last_pc, last_p4); end
  endtask

  task automatic test_align();
    gnt_pct = 0; rdy_pct = 100; lat_lo = 1; lat_hi = 2;
    repeat (20) run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h103);
    run_cycle(1'b0, 32'h0);
    n_vec++; if (last_addr !== 32'h100) begin n_err++; $display("FAIL align_addr got=%h exp=100", last_addr); end
    run_cycle(1'b1, 32'hFFFF_FFFC);
    gnt_pct = 100;
    run_cycle(1'b0, 32'h0);
    n_vec++; if (last_addr !== 32'hFFFF_FFFC || last_req !== 1'b1) begin n_err++; $display("FAIL wrap_pre got=%h/%b exp=fffffffc/1", last_addr, last_req); end
    run_cycle(1'b0, 32'h0);
    n_vec++; if (last_addr !== 32'h0) begin n_err++; $display("FAIL wrap_post got=%h exp=0", last_addr); end
    repeat (10) run_cycle(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 1; lat_hi = 1;
    repeat (4) run_cycle(1'b0, 32'h0);
    n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid_before got=%b exp=1", last_valid); end
    do_reset();
    #1;
    n_vec++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_after got=%b/%h exp=0/0", instr_valid, imem_addr); end
    repeat (10) run_cycle(1'b0, 32'h0);
    n_vec++; if (n_issued != DEPTH) begin n_err++; $display("FAIL mid_credits got=%0d exp=%0d", n_issued, DEPTH); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      gnt_pct = $urandom_range(100, 20); rdy_pct = $urandom_range(100, 10);
      lat_lo = 1; lat_hi = $urandom_range(4, 1);
      for (int k = 0; k < 50; k++) begin
        rpc = $urandom;
        run_cycle(($urandom_range(99) < 6), rpc);
      end
    end
    gnt_pct = 0; rdy_pct = 100;
    repeat (20) run_cycle(1'b0, 32'h0);
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    n_vec++; if (stat_fetched !== 32'h0 || stat_flushed !== 32'h0) begin n_err++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_fetched, stat_flushed); end
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 20 && n_issued < 5; k++) run_cycle(1'b0, 32'h0);
    gnt_pct = 0;
    repeat (6) run_cycle(1'b0, 32'h0);
    rdy_pct = 0; lat_lo = 3; lat_hi = 3;
    gnt_pct = 100; run_cycle(1'b0, 32'h0); run_cycle(1'b0, 32'h0);
    gnt_pct = 0;   run_cycle(1'b0, 32'h0);
    gnt_pct = 100; run_cycle(1'b0, 32'h0);
    gnt_pct = 0;   run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h200);
    repeat (4) run_cycle(1'b0, 32'h0);
    #1;
    n_vec++; if (stat_fetched !== 32'd5) begin n_err++; $display("FAIL stat_fetched got=%0d exp=5", stat_fetched); end
    n_vec++; if (stat_flushed !== 32'd3) begin n_err++; $display("FAIL stat_flushed got=%0d exp=3", stat_flushed); end
  endtask
`endif

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    gnt_pct = 0; rdy_pct = 0; lat_lo = 1; lat_hi = 1;
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_align();
    test_reset_mid();
    test_random();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
